// File: rtl/axi_rd_split_pkg.sv
// Shared types and helpers for the AXI4 read splitter (axi_rd_splitter, axi_rd_split_trk).
package axi_rd_split_pkg;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_e;

    typedef struct packed {
        logic last;
    } trk_entry_t;

    localparam int unsigned BOUNDARY_BYTES = 4096;

    // Beats the next INCR piece may carry. The distance to the 4 KB boundary is
    // measured from the size-aligned address, so an unaligned first beat still gets >= 1 beat.
    function automatic logic [8:0] piece_beats(
        input logic [11:0] addr,
        input logic [2:0]  size,
        input logic [8:0]  rem,
        input logic [8:0]  max
    );
        logic [11:0] al;
        logic [12:0] to_bnd;
        logic [8:0]  p;
        al     = (addr >> size) << size;
        to_bnd = (13'(BOUNDARY_BYTES) - {1'b0, al}) >> size;
        p      = rem;
        if ({4'b0, p} > to_bnd) p = to_bnd[8:0];
        if (p > max) p = max;
        return p;
    endfunction

endpackage

// File: rtl/axi_rd_split_trk.sv
// Outstanding-piece tracker: small synchronous FIFO of trk_entry_t with full/empty flags.
module axi_rd_split_trk
    import axi_rd_split_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  logic i_push_last,
    input  logic i_pop,
    output logic o_head_last,
    output logic o_full,
    output logic o_empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    trk_entry_t    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full      = (r_count == CW'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign w_push      = i_push && !o_full;
    assign w_pop       = i_pop && !o_empty;
    assign o_head_last = r_mem[r_rd_ptr].last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr].last <= i_push_last;
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/axi_rd_splitter.sv
// AXI4 read splitter: cuts AR bursts at 4 KB / MAX_BEATS and merges R so one rlast per request.
// Define AXI_RD_SPLITTER_PERF_EN to build the split/stall performance counters.
module axi_rd_splitter
    import axi_rd_split_pkg::*;
#(
    parameter int ID_WIDTH   = 16,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int MISC_W     = 26,
    parameter int MAX_BEATS  = 64,
    parameter int TRK_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_arid,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic [7:0]            s_arlen,
    input  logic [2:0]            s_arsize,
    input  logic [1:0]            s_arburst,
    input  logic [MISC_W-1:0]     s_armisc,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [ID_WIDTH-1:0]   s_rid,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rlast,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [ID_WIDTH-1:0]   m_arid,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic [MISC_W-1:0]     m_armisc,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [ID_WIDTH-1:0]   m_rid,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic [31:0]           perf_split_cnt,
    output logic [31:0]           perf_stall_cnt
);
    localparam int SIZE_MAX = $clog2(DATA_WIDTH / 8);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [MISC_W-1:0]     r_misc;
    logic [8:0]            r_rem;

    logic                  w_split;
    logic [8:0]            w_piece;
    logic                  w_last;
    logic                  w_s_ar_fire;
    logic                  w_ar_fire;
    logic [ADDR_WIDTH-1:0] w_size_mask;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic                  w_trk_full;
    logic                  w_trk_empty;
    logic                  w_trk_head_last;
    logic                  w_trk_pop;

    // Only INCR bursts with a beat no wider than the data bus are cut; others go out whole.
    assign w_split     = (r_burst == 2'b01) && (r_size <= 3'(SIZE_MAX));
    assign w_piece     = w_split ? piece_beats(r_addr[11:0], r_size, r_rem, 9'(MAX_BEATS)) : r_rem;
    assign w_last      = (r_rem == w_piece);
    assign w_s_ar_fire = s_arvalid && s_arready;
    assign w_ar_fire   = m_arvalid && m_arready;
    assign w_size_mask = (ADDR_WIDTH'(1) << r_size) - ADDR_WIDTH'(1);
    assign w_addr_nxt  = (r_addr & ~w_size_mask) + (ADDR_WIDTH'(w_piece) << r_size);

    always_comb begin
        w_state_nxt = r_state;
        s_arready   = 1'b0;
        m_arvalid   = 1'b0;
        case (r_state)
            IDLE: begin
                s_arready = 1'b1;
                if (s_arvalid) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                m_arvalid = !w_trk_full;
                if (m_arvalid && m_arready && w_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_misc  <= '0;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_s_ar_fire) begin
                r_id    <= s_arid;
                r_addr  <= s_araddr;
                r_size  <= s_arsize;
                r_burst <= s_arburst;
                r_misc  <= s_armisc;
                r_rem   <= {1'b0, s_arlen} + 9'd1;
            end else if (w_ar_fire) begin
                r_addr <= w_addr_nxt;
                r_rem  <= r_rem - w_piece;
            end
        end
    end

    assign m_arid    = r_id;
    assign m_araddr  = r_addr;
    assign m_arlen   = (r_state == ISSUE) ? 8'(w_piece - 9'd1) : 8'd0;
    assign m_arsize  = r_size;
    assign m_arburst = r_burst;
    assign m_armisc  = r_misc;

    assign w_trk_pop = m_rvalid && m_rready && m_rlast;

    axi_rd_split_trk #(
        .DEPTH (TRK_DEPTH)
    ) u_trk (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_ar_fire),
        .i_push_last (w_last),
        .i_pop       (w_trk_pop),
        .o_head_last (w_trk_head_last),
        .o_full      (w_trk_full),
        .o_empty     (w_trk_empty)
    );

    assign s_rvalid = m_rvalid;
    assign m_rready = s_rready;
    assign s_rid    = m_rid;
    assign s_rdata  = m_rdata;
    assign s_rresp  = m_rresp;
    assign s_rlast  = m_rlast && w_trk_head_last && !w_trk_empty;

    // R data with nothing outstanding means the downstream slave broke ordering.
    a_r_needs_piece: assert property (@(posedge clk) disable iff (rst) !(m_rvalid && w_trk_empty));

`ifdef AXI_RD_SPLITTER_PERF_EN
    logic [31:0] r_split_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_split_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_ar_fire && !w_last && (r_split_cnt != '1)) r_split_cnt <= r_split_cnt + 32'd1;
            if ((r_state == ISSUE) && w_trk_full && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign perf_split_cnt = r_split_cnt;
    assign perf_stall_cnt = r_stall_cnt;
`else
    assign perf_split_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_axi_rd_splitter.sv
// Scoreboard bench for axi_rd_splitter: AR pieces and R beats are predicted at request time.
module tb_axi_rd_splitter;

    logic         clk;
    logic         rst;
    logic [15:0]  s_arid;
    logic [63:0]  s_araddr;
    logic [7:0]   s_arlen;
    logic [2:0]   s_arsize;
    logic [1:0]   s_arburst;
    logic [25:0]  s_armisc;
    logic         s_arvalid;
    logic         s_arready;
    logic [15:0]  s_rid;
    logic [511:0] s_rdata;
    logic [1:0]   s_rresp;
    logic         s_rlast;
    logic         s_rvalid;
    logic         s_rready;
    logic [15:0]  m_arid;
    logic [63:0]  m_araddr;
    logic [7:0]   m_arlen;
    logic [2:0]   m_arsize;
    logic [1:0]   m_arburst;
    logic [25:0]  m_armisc;
    logic         m_arvalid;
    logic         m_arready;
    logic [15:0]  m_rid;
    logic [511:0] m_rdata;
    logic [1:0]   m_rresp;
    logic         m_rlast;
    logic         m_rvalid;
    logic         m_rready;
    logic [31:0]  perf_split_cnt;
    logic [31:0]  perf_stall_cnt;

    axi_rd_splitter dut (
        .clk(clk), .rst(rst),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_armisc(s_armisc), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_armisc(m_armisc), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .perf_split_cnt(perf_split_cnt), .perf_stall_cnt(perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // {id[118:103], addr[102:39], len[38:31], size[30:28], burst[27:26], misc[25:0]}
    logic [118:0] exp_ar_q[$];
    // {id[48:33], last[32], seq[31:0]}
    logic [48:0]  exp_r_q[$];
    logic [31:0]  exp_seq = 0;

    int dn_len_q[$];
    logic [15:0] dn_id_q[$];
    logic [31:0] dn_seq = 0;
    int beat_idx = 0;

    bit r_hold = 0, ar_rand = 1, dn_rand = 1, up_rand = 1, up_hold = 0;
    int ar_cnt = 0, r_cnt = 0, r_last_cnt = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference split: cut INCR bursts at the 4 KB line (from the aligned address) and at 64 beats.
    task automatic model_req(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [25:0] misc);
        int rem, p, to_bnd;
        logic [63:0] a, al;
        rem = int'(len) + 1;
        a = addr;
        while (rem > 0) begin
            if (burst == 2'b01 && size <= 3'd6) begin
                al = (a >> size) << size;
                to_bnd = (4096 - int'(al[11:0])) >> size;
                p = rem;
                if (to_bnd < p) p = to_bnd;
                if (64 < p) p = 64;
            end else begin
                al = a;
                p = rem;
            end
            exp_ar_q.push_back({id, a, 8'(p - 1), size, burst, misc});
            a = al + (64'(p) << size);
            rem -= p;
        end
        for (int i = 0; i <= int'(len); i++) begin
            exp_r_q.push_back({id, (i == int'(len)), exp_seq});
            exp_seq++;
        end
    endtask

    task automatic send_req(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        logic [25:0] misc;
        bit got;
        misc = 26'($urandom);
        model_req(id, addr, len, size, burst, misc);
        @(posedge clk); #1;
        s_arvalid = 1; s_arid = id; s_araddr = addr; s_arlen = len;
        s_arsize = size; s_arburst = burst; s_armisc = misc;
        got = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (s_arready) begin got = 1; break; end
        end
        @(posedge clk); #1;
        s_arvalid = 0;
        if (!got) check("s_ar_accept_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            if (exp_r_q.size() == 0 && exp_ar_q.size() == 0 && dn_len_q.size() == 0) break;
        end
        check("drain_r_left", exp_r_q.size(), 0);
        check("drain_ar_left", exp_ar_q.size(), 0);
    endtask

    // AR scoreboard
    logic [118:0] ar_e;
    always @(negedge clk) begin
        if (!rst && m_arvalid && m_arready) begin
            ar_cnt++;
            if (exp_ar_q.size() == 0) check("ar_unexpected", 1, 0);
            else begin
                ar_e = exp_ar_q.pop_front();
                check("ar_id", m_arid, ar_e[118:103]);
                check("ar_addr", m_araddr, ar_e[102:39]);
                check("ar_len", m_arlen, ar_e[38:31]);
                check("ar_size", m_arsize, ar_e[30:28]);
                check("ar_burst", m_arburst, ar_e[27:26]);
                check("ar_misc", m_armisc, ar_e[25:0]);
            end
        end
    end

    // R scoreboard
    logic [48:0] r_e;
    always @(negedge clk) begin
        if (!rst && s_rvalid && s_rready) begin
            r_cnt++;
            if (s_rlast) r_last_cnt++;
            if (exp_r_q.size() == 0) check("r_unexpected", 1, 0);
            else begin
                r_e = exp_r_q.pop_front();
                check("r_data", s_rdata, {16{r_e[31:0]}});
                check("r_id", s_rid, r_e[48:33]);
                check("r_last", s_rlast, r_e[32]);
                check("r_resp", s_rresp, r_e[1:0]);
            end
        end
    end

    // Downstream slave: returns pieces in issue order, data = running beat number
    bit dn_ar_fire, dn_r_fire;
    logic [7:0] dn_len_s;
    logic [15:0] dn_id_s;
    initial begin
        m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rdata = 0; m_rid = 0; m_rresp = 0;
        forever begin
            @(negedge clk);
            dn_ar_fire = m_arvalid && m_arready;
            dn_len_s = m_arlen;
            dn_id_s = m_arid;
            dn_r_fire = m_rvalid && m_rready;
            @(posedge clk); #1;
            if (rst) begin
                dn_len_q.delete(); dn_id_q.delete();
                beat_idx = 0; dn_seq = 0; m_rvalid = 0; m_rlast = 0;
            end else begin
                if (dn_r_fire) begin
                    beat_idx++;
                    dn_seq++;
                    if (beat_idx == dn_len_q[0]) begin
                        void'(dn_len_q.pop_front());
                        void'(dn_id_q.pop_front());
                        beat_idx = 0;
                    end
                end
                if (dn_ar_fire) begin
                    dn_len_q.push_back(int'(dn_len_s) + 1);
                    dn_id_q.push_back(dn_id_s);
                end
                if (!(m_rvalid && !dn_r_fire)) begin
                    if (dn_len_q.size() > 0 && !r_hold && (!dn_rand || $urandom_range(0, 3) != 0)) begin
                        m_rvalid = 1;
                        m_rdata = {16{dn_seq}};
                        m_rid = dn_id_q[0];
                        m_rresp = dn_seq[1:0];
                        m_rlast = (beat_idx == dn_len_q[0] - 1);
                    end else begin
                        m_rvalid = 0;
                        m_rlast = 0;
                    end
                end
            end
            m_arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Upstream R consumer
    initial begin
        s_rready = 0;
        forever begin
            @(posedge clk); #1;
            s_rready = (rst || up_hold) ? 1'b0 : (up_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    int base;
    logic [511:0] d0;
    initial begin
        rst = 1; s_arvalid = 0; s_arid = 0; s_araddr = 0; s_arlen = 0;
        s_arsize = 0; s_arburst = 0; s_armisc = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_arready", s_arready, 1);
        check("rst_m_arvalid", m_arvalid, 0);
        check("rst_m_araddr", m_araddr, 0);
        check("rst_m_arlen", m_arlen, 0);
        check("rst_s_rvalid", s_rvalid, 0);
        check("rst_s_rlast", s_rlast, 0);
        check("rst_m_rready", m_rready, 0);
        check("rst_perf_split", perf_split_cnt, 0);
        check("rst_perf_stall", perf_stall_cnt, 0);
        @(posedge clk); #1;
        rst = 0;

        // 4 KB boundary split: 0xFC0 len0 then 0x1000 len6
        base = ar_cnt;
        send_req(16'h0011, 64'h0FC0, 8'd7, 3'd6, 2'b01);
        wait_drain();
        check("bnd_pieces", ar_cnt - base, 2);
        check("bnd_rlast_cnt", r_last_cnt, 1);
`ifdef AXI_RD_SPLITTER_PERF_EN
        check("bnd_perf_split", perf_split_cnt, 1);
`endif

        // Length split: four 64-beat pieces
        base = ar_cnt;
        send_req(16'h0022, 64'h0, 8'd255, 3'd6, 2'b01);
        wait_drain();
        check("len_pieces", ar_cnt - base, 4);
        check("len_rlast_cnt", r_last_cnt, 2);
`ifdef AXI_RD_SPLITTER_PERF_EN
        check("len_perf_split", perf_split_cnt, 4);
`endif

        // Unsplit cases: small INCR, FIXED, WRAP, oversized beat
        base = ar_cnt;
        send_req(16'h0033, 64'h40, 8'd3, 3'd6, 2'b01);
        send_req(16'h0034, 64'h0FC0, 8'd15, 3'd6, 2'b00);
        send_req(16'h0035, 64'h0FC0, 8'd3, 3'd6, 2'b10);
        send_req(16'h0036, 64'h0F80, 8'd3, 3'd7, 2'b01);
        wait_drain();
        check("nosplit_pieces", ar_cnt - base, 4);

        // Random INCR traffic
        for (int i = 0; i < 8; i++) begin
            send_req(16'($urandom), {$urandom, $urandom}, 8'($urandom_range(0, 255)),
                     3'($urandom_range(0, 6)), 2'b01);
        end
        wait_drain();

        // Tracker full: R withheld, five single-piece requests
        ar_rand = 0; r_hold = 1;
        base = ar_cnt;
        for (int i = 0; i < 5; i++) send_req(16'(16'h0050 + i), 64'h5000 + 64'(i * 64), 8'd0, 3'd6, 2'b01);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("full_issued", ar_cnt - base, 4);
        check("full_m_arvalid", m_arvalid, 0);
        check("full_s_arready", s_arready, 0);
`ifdef AXI_RD_SPLITTER_PERF_EN
        check("full_perf_stall_nz", (perf_stall_cnt != 0), 1);
`endif
        r_hold = 0;
        wait_drain();
        check("full_all_issued", ar_cnt - base, 5);

        // Backpressure on upstream R mid-burst
        dn_rand = 0; up_rand = 0;
        base = r_cnt;
        send_req(16'h0044, 64'h2000, 8'd15, 3'd6, 2'b01);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (r_cnt - base >= 4) break;
        end
        up_hold = 1;
        @(posedge clk);
        @(negedge clk);
        d0 = s_rdata;
        base = r_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_m_rready", m_rready, 0);
            check("bp_s_rvalid", s_rvalid, 1);
            check("bp_s_rdata_stable", s_rdata, d0);
        end
        check("bp_no_beats", r_cnt - base, 0);
        up_hold = 0;
        wait_drain();
        up_rand = 1; dn_rand = 1;

        // Reset while piece 2 of 4 is pending
        r_hold = 1;
        base = ar_cnt;
        send_req(16'h0055, 64'h0, 8'd255, 3'd6, 2'b01);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (ar_cnt - base >= 1) break;
        end
        #1 rst = 1;
        @(negedge clk);
        check("mid_rst_s_arready", s_arready, 1);
        check("mid_rst_m_arvalid", m_arvalid, 0);
        check("mid_rst_m_araddr", m_araddr, 0);
        repeat (2) @(posedge clk);
        exp_ar_q.delete();
        exp_r_q.delete();
        exp_seq = 0;
        #1 rst = 0;
        r_hold = 0;
        base = r_last_cnt;
        send_req(16'h0066, 64'h40, 8'd3, 3'd6, 2'b01);
        wait_drain();
        check("post_rst_rlast", r_last_cnt - base, 1);

`ifndef AXI_RD_SPLITTER_PERF_EN
        check("perf_split_tied", perf_split_cnt, 0);
        check("perf_stall_tied", perf_stall_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
